// File: rtl/wd_service_gen.sv
// -----------------------------------------------------------------------------
// wd_service_gen
//
// Initiating side of the frame-window watchdog. Issues single-cycle WDSRVC
// pulses to the frame-window counter, but only inside a configurable service
// window and only after the application has shown liveness on HBEAT.
// Watches the counter's FW_OVR feedback and latches sticky miss and fault
// status for the supervisor.
//
// Parameters:
//   CW         width of the interval counter and window bounds (matches FWLEN)
//
// Ports:
//   FWCLK      in   1   clock, rising edge
//   WDRST      in   1   synchronous active-high reset
//   EN         in   1   service enable; 0 forces IDLE except from FAULT
//   HBEAT      in   1   application heartbeat, sampled every cycle
//   WIN_OPEN   in   CW  earliest interval count at which service is allowed
//   WIN_CLOSE  in   CW  latest interval count at which service is allowed
//   FW_OVR     in   1   overflow flag from the frame-window counter
//   WDSRVC     out  1   registered service pulse, one cycle wide
//   SRVC_CNT   out  CW  number of services issued, wraps modulo 2^CW
//   MISS       out  1   sticky: window closed without a heartbeat
//   FAULT      out  1   sticky: FW_OVR seen while active
//   STATE      out  3   current FSM state encoding
// -----------------------------------------------------------------------------
module wd_service_gen #(
    parameter int CW = 8
) (
    input  logic          FWCLK,
    input  logic          WDRST,
    input  logic          EN,
    input  logic          HBEAT,
    input  logic [CW-1:0] WIN_OPEN,
    input  logic [CW-1:0] WIN_CLOSE,
    input  logic          FW_OVR,
    output logic          WDSRVC,
    output logic [CW-1:0] SRVC_CNT,
    output logic          MISS,
    output logic          FAULT,
    output logic [2:0]    STATE
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_OPEN = 3'd1,
        S_ARMED     = 3'd2,
        S_KICK      = 3'd3,
        S_MISSED    = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] q;        // cycles elapsed in the current interval
    logic          hb_seen;  // heartbeat observed since the last service

    // Interval counter sticks at all-ones rather than wrapping, so a stalled
    // interval can never appear to re-enter the window.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign STATE = state;

    always_ff @(posedge FWCLK) begin
        if (WDRST) begin
            state    <= S_IDLE;
            q        <= '0;
            hb_seen  <= 1'b0;
            WDSRVC   <= 1'b0;
            SRVC_CNT <= '0;
            MISS     <= 1'b0;
            FAULT    <= 1'b0;
        end else begin
            // The pulse is raised only on the edge that enters KICK, so it
            // drops automatically one cycle later.
            WDSRVC <= 1'b0;

            if (FW_OVR && (state != S_IDLE)) begin
                // Counter overflow outranks everything, including a kick that
                // would otherwise be issued on this edge.
                state   <= S_FAULT;
                FAULT   <= 1'b1;
                hb_seen <= hb_seen | HBEAT;
            end else if (!EN && (state != S_FAULT)) begin
                // Disabling drops back to IDLE; sticky status and the service
                // count are deliberately left untouched.
                state   <= S_IDLE;
                q       <= '0;
                hb_seen <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        q       <= '0;
                        hb_seen <= 1'b0;
                        if (EN) begin
                            state <= S_WAIT_OPEN;
                        end
                    end

                    S_WAIT_OPEN: begin
                        q <= sat_inc(q);
                        if (HBEAT) begin
                            hb_seen <= 1'b1;
                        end
                        if (q == WIN_OPEN) begin
                            state <= S_ARMED;
                        end
                    end

                    S_ARMED: begin
                        q <= sat_inc(q);
                        // A heartbeat wins over window close in the same cycle.
                        if (hb_seen || HBEAT) begin
                            state    <= S_KICK;
                            WDSRVC   <= 1'b1;
                            SRVC_CNT <= SRVC_CNT + CW'(1);
                            hb_seen  <= 1'b1;
                        end else if (q >= WIN_CLOSE) begin
                            state <= S_MISSED;
                            MISS  <= 1'b1;
                        end
                    end

                    S_KICK: begin
                        // Liveness must be shown afresh for every interval.
                        q       <= '0;
                        hb_seen <= 1'b0;
                        state   <= S_WAIT_OPEN;
                    end

                    S_MISSED: begin
                        // Service withheld so the frame window is left to expire.
                        if (HBEAT) begin
                            hb_seen <= 1'b1;
                        end
                    end

                    S_FAULT: begin
                        FAULT <= 1'b1;
                        if (HBEAT) begin
                            hb_seen <= 1'b1;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                        q     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wd_service_gen.sv
// -----------------------------------------------------------------------------
// tb_wd_service_gen
//
// Directed self-checking bench for wd_service_gen. Inputs are driven 1 time
// unit after each rising edge and outputs are sampled at the same point, so
// every observation reflects the state loaded by the preceding edge.
// Cycle n of an interval is counted from the KICK (or enabling IDLE) cycle.
// -----------------------------------------------------------------------------
module tb_wd_service_gen;

    localparam int CW = 8;

    logic          FWCLK;
    logic          WDRST;
    logic          EN;
    logic          HBEAT;
    logic [CW-1:0] WIN_OPEN;
    logic [CW-1:0] WIN_CLOSE;
    logic          FW_OVR;
    logic          WDSRVC;
    logic [CW-1:0] SRVC_CNT;
    logic          MISS;
    logic          FAULT;
    logic [2:0]    STATE;

    int checks = 0;
    int errors = 0;

    wd_service_gen #(.CW(CW)) dut (
        .FWCLK     (FWCLK),
        .WDRST     (WDRST),
        .EN        (EN),
        .HBEAT     (HBEAT),
        .WIN_OPEN  (WIN_OPEN),
        .WIN_CLOSE (WIN_CLOSE),
        .FW_OVR    (FW_OVR),
        .WDSRVC    (WDSRVC),
        .SRVC_CNT  (SRVC_CNT),
        .MISS      (MISS),
        .FAULT     (FAULT),
        .STATE     (STATE)
    );

    initial FWCLK = 1'b0;
    always #5 FWCLK = ~FWCLK;

    task automatic tick();
        @(posedge FWCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        WDRST = 1'b1;
        tick();
        tick();
        WDRST = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_srvc"}, 32'(WDSRVC), 32'd0);
        chk({tag, "_cnt"},  32'(SRVC_CNT), 32'd0);
        chk({tag, "_miss"}, 32'(MISS), 32'd0);
        chk({tag, "_fault"}, 32'(FAULT), 32'd0);
        chk({tag, "_state"}, 32'(STATE), 32'd0);
    endtask

    initial begin
        WDRST     = 1'b1;
        EN        = 1'b0;
        HBEAT     = 1'b0;
        WIN_OPEN  = 8'd4;
        WIN_CLOSE = 8'd10;
        FW_OVR    = 1'b0;

        // ---- reset state
        do_reset();
        chk_reset_vals("rst");

        // ---- nominal: window 4/10, heartbeat held, pulse every 7 cycles
        EN    = 1'b1;
        HBEAT = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 1) chk("nom_wait_open", 32'(STATE), 32'd1);
            chk("nom_srvc", 32'(WDSRVC), 32'(c % 7 == 0));
            chk("nom_cnt", 32'(SRVC_CNT), 32'(c / 7));
        end
        chk("nom_miss", 32'(MISS), 32'd0);
        chk("nom_fault", 32'(FAULT), 32'd0);

        // ---- late heartbeat: single pulse at interval count 9 (cycle K+10)
        HBEAT = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk("late_quiet", 32'(WDSRVC), 32'd0);
        end
        chk("late_armed", 32'(STATE), 32'd2);
        HBEAT = 1'b1;
        tick();
        HBEAT = 1'b0;
        chk("late_srvc", 32'(WDSRVC), 32'd1);
        chk("late_cnt", 32'(SRVC_CNT), 32'd4);
        chk("late_miss", 32'(MISS), 32'd0);

        // ---- heartbeat in the same cycle q reaches WIN_CLOSE (cycle K+11)
        for (int n = 1; n <= 11; n++) begin
            tick();
            chk("close_quiet", 32'(WDSRVC), 32'd0);
        end
        chk("close_armed", 32'(STATE), 32'd2);
        HBEAT = 1'b1;
        tick();
        HBEAT = 1'b0;
        chk("close_srvc", 32'(WDSRVC), 32'd1);
        chk("close_miss", 32'(MISS), 32'd0);
        chk("close_cnt", 32'(SRVC_CNT), 32'd5);

        // ---- reset pulsed in WAIT_OPEN with SRVC_CNT=5
        tick();
        chk("rstmid_wait", 32'(STATE), 32'd1);
        chk("rstmid_cnt5", 32'(SRVC_CNT), 32'd5);
        WDRST = 1'b1;
        tick();
        WDRST = 1'b0;
        chk_reset_vals("rstmid");

        // ---- missed window: EN already high in this IDLE cycle, no heartbeat
        for (int n = 1; n <= 11; n++) begin
            tick();
            chk("miss_quiet", 32'(WDSRVC), 32'd0);
            chk("miss_early", 32'(MISS), 32'd0);
        end
        tick();
        chk("miss_rise", 32'(MISS), 32'd1);
        chk("miss_state", 32'(STATE), 32'd4);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("miss_hold_srvc", 32'(WDSRVC), 32'd0);
            chk("miss_hold_state", 32'(STATE), 32'd4);
        end
        FW_OVR = 1'b1;
        tick();
        FW_OVR = 1'b0;
        chk("ovr_fault", 32'(FAULT), 32'd1);
        chk("ovr_state", 32'(STATE), 32'd5);
        EN = 1'b0;
        tick();
        tick();
        chk("fault_ignores_en", 32'(STATE), 32'd5);
        chk("fault_sticky", 32'(FAULT), 32'd1);

        // ---- FW_OVR in the ARMED cycle that would kick
        do_reset();
        EN = 1'b1;
        for (int n = 1; n <= 7; n++) tick();
        chk("ovrkick_armed", 32'(STATE), 32'd2);
        HBEAT  = 1'b1;
        FW_OVR = 1'b1;
        tick();
        HBEAT  = 1'b0;
        FW_OVR = 1'b0;
        chk("ovrkick_srvc", 32'(WDSRVC), 32'd0);
        chk("ovrkick_fault", 32'(FAULT), 32'd1);
        chk("ovrkick_state", 32'(STATE), 32'd5);
        chk("ovrkick_cnt", 32'(SRVC_CNT), 32'd0);

        // ---- EN=0 in ARMED with MISS already set
        do_reset();
        EN = 1'b1;
        for (int n = 1; n <= 12; n++) tick();
        chk("en_premiss", 32'(MISS), 32'd1);
        EN = 1'b0;
        tick();
        chk("en_idle_from_missed", 32'(STATE), 32'd0);
        EN = 1'b1;
        for (int n = 1; n <= 6; n++) tick();
        chk("en_armed", 32'(STATE), 32'd2);
        EN = 1'b0;
        tick();
        chk("en_idle", 32'(STATE), 32'd0);
        chk("en_miss_kept", 32'(MISS), 32'd1);
        chk("en_fault_kept", 32'(FAULT), 32'd0);
        chk("en_srvc", 32'(WDSRVC), 32'd0);

        // ---- inverted window 4/2: ARMED at n=6 with q=5 misses at once
        do_reset();
        WIN_CLOSE = 8'd2;
        EN = 1'b1;
        for (int n = 1; n <= 6; n++) tick();
        chk("inv_armed", 32'(STATE), 32'd2);
        chk("inv_nomiss", 32'(MISS), 32'd0);
        tick();
        chk("inv_miss", 32'(MISS), 32'd1);
        chk("inv_state", 32'(STATE), 32'd4);

        // ---- wrap: window 0/3, heartbeat held, 256 services every 3 cycles
        EN = 1'b0;
        do_reset();
        WIN_OPEN  = 8'd0;
        WIN_CLOSE = 8'd3;
        HBEAT     = 1'b1;
        EN        = 1'b1;
        for (int c = 1; c <= 768; c++) begin
            tick();
            chk("wrap_srvc", 32'(WDSRVC), 32'(c % 3 == 0));
            chk("wrap_cnt", 32'(SRVC_CNT), 32'((c / 3) % 256));
        end
        chk("wrap_zero", 32'(SRVC_CNT), 32'd0);
        chk("wrap_miss", 32'(MISS), 32'd0);
        chk("wrap_fault", 32'(FAULT), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wd_service_gen.md
# wd_service_gen

Watchdog service generator: the initiating side of the frame-window watchdog. It issues single-cycle `WDSRVC` pulses to the frame-window counter, but only inside a configurable service window and only after the application has shown liveness on `HBEAT`. It watches the counter's `FW_OVR` feedback and latches sticky miss and fault status for the supervisor.

## Interface
Parameters:
- `CW`, 8, width of the interval counter and window bounds; matches the `FWLEN` width.

Ports (one clock; reset is synchronous and active-high):
- `FWCLK`  in  1  clock; all logic runs on the rising edge.
- `WDRST`  in  1  synchronous active-high reset.
- `EN`  in  1  service enable; 0 forces IDLE, except from FAULT.
- `HBEAT`  in  1  application heartbeat; any-width pulse, sampled each cycle.
- `WIN_OPEN`  in  CW  earliest interval count at which service is allowed.
- `WIN_CLOSE`  in  CW  latest interval count at which service is allowed.
- `FW_OVR`  in  1  overflow flag from the frame-window counter.
- `WDSRVC`  out  1  registered service pulse, exactly 1 cycle wide.
- `SRVC_CNT`  out  CW  count of issued services; wraps modulo 2^CW.
- `MISS`  out  1  sticky; the window closed without a heartbeat.
- `FAULT`  out  1  sticky; `FW_OVR` was seen while active.
- `STATE`  out  3  current FSM state encoding.

## Operation
- Internal registers:
  - `q`: interval counter, CW bits, saturates at 2^CW-1.
  - `hb_seen`: set by `HBEAT`=1 in any non-IDLE state; cleared on KICK and on entry to IDLE.
- FSM states (encoding in brackets):
  - IDLE [0]: `q`=0. If `EN`=1, go to WAIT_OPEN.
  - WAIT_OPEN [1]: `q`++ each cycle. When `q`==`WIN_OPEN`, go to ARMED.
  - ARMED [2]: `q`++ each cycle.
    - If `hb_seen`|`HBEAT`, go to KICK.
    - Otherwise, if `q`>=`WIN_CLOSE`, set `MISS` and go to MISSED.
    - Heartbeat beats window close in the same cycle.
  - KICK [3]: `WDSRVC`=1 for this cycle only. `q`<=0, `hb_seen`<=0, `SRVC_CNT`++. Go to WAIT_OPEN.
  - MISSED [4]: `WDSRVC` is held at 0 so the frame window is allowed to expire. Exits only via the priorities below.
  - FAULT [5]: `WDSRVC` is held at 0. `FAULT`=1. Exits only on `WDRST`.
- Transition priority, highest first:
  1. `WDRST`.
  2. `FW_OVR`=1 in any state other than IDLE: set `FAULT` and go to FAULT.
  3. `EN`=0 in any state other than FAULT: go to IDLE. `MISS`, `FAULT` and `SRVC_CNT` keep their values.
  4. The normal transitions listed above.
- `WIN_CLOSE` < `WIN_OPEN` is not rejected. ARMED then misses on its first cycle unless a heartbeat has already been seen.
- `WIN_OPEN` and `WIN_CLOSE` are sampled live each cycle. Software changes them only while `EN`=0.

## Timing
- Reset values: `WDSRVC`=0, `SRVC_CNT`=0, `MISS`=0, `FAULT`=0, `STATE`=IDLE, `q`=0, `hb_seen`=0.
- `EN` rises in cycle t: WAIT_OPEN in t+1 with `q`=0.
- KICK in cycle K:
  - Next `WDSRVC` no earlier than K+`WIN_OPEN`+3.
  - Next `WDSRVC` no later than K+`WIN_CLOSE`+2.
  - If neither happens, `MISS` rises at K+`WIN_CLOSE`+2.
- The first interval after `EN` rises has the same bounds, measured from the first WAIT_OPEN cycle minus one.
- `HBEAT` sampled in ARMED at cycle t: `WDSRVC`=1 at t+1.
- `FW_OVR` at cycle t:
  - `FAULT`=1 and `STATE`=5 at t+1.
  - A KICK already scheduled for t+1 is suppressed.
- `SRVC_CNT` updates in the same edge that raises `WDSRVC`. At 2^CW-1 it wraps to 0.
- `WDSRVC` is never high in two consecutive cycles.
- Integration rule: `WIN_CLOSE`+2 < `FWLEN`, so a serviced system never overflows.

## Test plan
- Nominal servicing: `WIN_OPEN`=4, `WIN_CLOSE`=10, `HBEAT` held 1, `EN` asserted in cycle 0.
  - Required: `WDSRVC` pulses every 7 cycles (4+3).
  - Required: `SRVC_CNT` increments once per pulse.
  - Required: `MISS` and `FAULT` stay 0.
- Late heartbeat: window 4/10, single `HBEAT` pulse at interval count 9.
  - Required: `WDSRVC` one cycle later.
  - Required: no `MISS`.
- Missed window: window 4/10, no `HBEAT`.
  - Required: `MISS`=1 at K+12.
  - Required: `STATE`=4 and `WDSRVC` held at 0.
  - Then drive `FW_OVR`=1: `FAULT`=1 and `STATE`=5 on the next cycle.
- Simultaneous events:
  - `HBEAT`=1 in the same cycle `q` reaches `WIN_CLOSE`: service issued, `MISS` stays 0.
  - `FW_OVR`=1 in the ARMED cycle that would kick: no `WDSRVC`, `FAULT`=1.
- Reset and enable mid-operation:
  - `WDRST` pulsed in WAIT_OPEN with `SRVC_CNT`=5: all outputs at reset values on the next cycle.
  - `EN`=0 in ARMED: IDLE next cycle, `MISS` and `FAULT` unchanged.
- Wrap: 256 services with window 0/3 and `HBEAT`=1.
  - Required: `SRVC_CNT` returns to 0.
  - Required: interval is exactly 3 cycles throughout.
